// File: rtl/rx_frame_checker_pkg.sv
// rx_frame_checker_pkg: framing constants, FSM states and CRC-16 shared by the TX framer and the RX frame checker
package rx_frame_checker_pkg;
  localparam logic [15:0] SYNC_HDR = 16'hCAFE;
  localparam logic [15:0] SYNC_FCS = 16'hC0DE;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam int DEF_NB_SAMPLES = 256;
  localparam int TS_PER_SAMPLE = 250;
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    TS_MSB  = 3'd1,
    TS_LSB  = 3'd2,
    PAYLOAD = 3'd3,
    FCS     = 3'd4
  } state_t;
  // MSB-first CRC-16 (poly 0x1021, no reflection) over one whole 32-bit word
  function automatic logic [15:0] crc16(input logic [15:0] crc, input logic [31:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    return c;
  endfunction
endpackage

// File: rtl/rx_frame_checker_crc.sv
// crc16_w32: registered CRC-16 accumulator, one 32-bit word per enabled cycle
// Ports: clk, reset_n (sync active-low), init (reload CRC_INIT, wins over en),
//        en (fold data into crc), data (32-bit word), crc (current value)
module crc16_w32
  import rx_frame_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [15:0] crc
);
  always_ff @(posedge clk)
    if (!reset_n || init) crc <= CRC_INIT;
    else if (en) crc <= crc16(crc, data);
endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: validates framed words from a FWFT FIFO and forwards payload samples
// Ports: i_clk/i_reset_n (sync active-low); i_empty/i_data/o_read FIFO pop side;
//        i_sink_full sink backpressure (stalls payload only); o_sample_valid/o_sample_data
//        payload strobe; o_frame_done/o_frame_ok/o_err_flags {ts,seq,fcs_sync,crc} per frame;
//        o_seqnum/o_timestamp last accepted values; o_frames_ok/o_frames_bad/o_hunt_drops counters
module rx_frame_checker
  import rx_frame_checker_pkg::*;
#(
  parameter int          NB_SAMPLES = DEF_NB_SAMPLES,
  parameter logic [63:0] TS_STEP    = 64'(DEF_NB_SAMPLES * TS_PER_SAMPLE)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_empty,
  input  logic [31:0] i_data,
  output logic        o_read,
  input  logic        i_sink_full,
  output logic        o_sample_valid,
  output logic [31:0] o_sample_data,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [3:0]  o_err_flags,
  output logic [14:0] o_seqnum,
  output logic [63:0] o_timestamp,
  output logic [15:0] o_frames_ok,
  output logic [15:0] o_frames_bad,
  output logic [15:0] o_hunt_drops
);
  state_t      state;
  logic        first;
  logic [14:0] prev_seq;
  logic [63:0] prev_ts;
  logic [31:0] ts_hi;
  logic [9:0]  cnt;
  logic        ts_err;
  logic        seq_err;
  logic [15:0] crc;
  logic        hdr_ok;
  logic [14:0] seq_next;
  logic [63:0] ts_in;
  logic [3:0]  flags;
  assign o_read   = !i_empty && (state != PAYLOAD || !i_sink_full);
  assign hdr_ok   = i_data[31:16] == SYNC_HDR && !i_data[15];
  assign seq_next = prev_seq + 15'd1;
  assign ts_in    = {ts_hi, i_data};
  assign flags    = {ts_err, seq_err, i_data[31:16] != SYNC_FCS, i_data[15:0] != crc};
  crc16_w32 u_crc (
    .clk    (i_clk),
    .reset_n(i_reset_n),
    .init   (o_read && state == TS_LSB),
    .en     (o_read && state == PAYLOAD),
    .data   (i_data),
    .crc    (crc)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state          <= HUNT;
      first          <= 1'b1;
      prev_seq       <= '0;
      prev_ts        <= '0;
      ts_hi          <= '0;
      cnt            <= '0;
      ts_err         <= 1'b0;
      seq_err        <= 1'b0;
      o_sample_valid <= 1'b0;
      o_sample_data  <= '0;
      o_frame_done   <= 1'b0;
      o_frame_ok     <= 1'b0;
      o_err_flags    <= '0;
      o_seqnum       <= '0;
      o_timestamp    <= '0;
      o_frames_ok    <= '0;
      o_frames_bad   <= '0;
      o_hunt_drops   <= '0;
    end else begin
      o_sample_valid <= 1'b0;
      o_frame_done   <= 1'b0;
      if (o_read)
        case (state)
          HUNT:
            if (hdr_ok) begin
              o_seqnum <= i_data[14:0];
              seq_err  <= !first && i_data[14:0] != seq_next;
              ts_err   <= 1'b0;
              state    <= TS_MSB;
            end else o_hunt_drops <= o_hunt_drops + 16'd1;
          TS_MSB: begin
            ts_hi <= i_data;
            state <= TS_LSB;
          end
          TS_LSB: begin
            o_timestamp <= ts_in;
            ts_err      <= !first && ts_in != prev_ts + TS_STEP;
            cnt         <= 10'(NB_SAMPLES - 1);
            state       <= PAYLOAD;
          end
          PAYLOAD: begin
            o_sample_valid <= 1'b1;
            o_sample_data  <= i_data;
            cnt            <= cnt - 10'd1;
            state          <= cnt == 10'd0 ? FCS : PAYLOAD;
          end
          FCS: begin
            o_frame_done <= 1'b1;
            o_err_flags  <= flags;
            o_frame_ok   <= flags == 4'd0;
            o_frames_ok  <= o_frames_ok + 16'(flags == 4'd0);
            o_frames_bad <= o_frames_bad + 16'(flags != 4'd0);
            prev_seq     <= o_seqnum;
            prev_ts      <= o_timestamp;
            // lost FCS sync means the stream position is suspect: skip continuity on the next frame
            first        <= flags[1];
            state        <= HUNT;
          end
          default: state <= HUNT;
        endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: randomized scoreboard bench for rx_frame_checker
module tb_rx_frame_checker;
  localparam int NS = 256;
  localparam logic [63:0] STEP = 64'd64000;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_empty = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_sink_full = 1'b0;
  logic        o_read, o_sample_valid, o_frame_done, o_frame_ok;
  logic [31:0] o_sample_data;
  logic [3:0]  o_err_flags;
  logic [14:0] o_seqnum;
  logic [63:0] o_timestamp;
  logic [15:0] o_frames_ok, o_frames_bad, o_hunt_drops;
  rx_frame_checker dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_empty(i_empty), .i_data(i_data),
    .o_read(o_read), .i_sink_full(i_sink_full), .o_sample_valid(o_sample_valid),
    .o_sample_data(o_sample_data), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
    .o_err_flags(o_err_flags), .o_seqnum(o_seqnum), .o_timestamp(o_timestamp),
    .o_frames_ok(o_frames_ok), .o_frames_bad(o_frames_bad), .o_hunt_drops(o_hunt_drops)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic [3:0]  flags;
    logic [15:0] nok, nbad, drops;
    logic [14:0] seq;
    logic [63:0] ts;
  } exp_t;
  logic [31:0] fifo_q[$];
  logic [31:0] samp_q[$];
  exp_t        frame_q[$];
  int checks = 0, failures = 0, samples_seen = 0, gap_pct = 0;
  bit          m_first = 1'b1;
  logic [14:0] m_prev_seq = '0;
  logic [63:0] m_prev_ts = '0;
  int          m_ok = 0, m_bad = 0, m_drops = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // CRC as the remainder of (crc*x^32 + word*x^16) divided by x^16+0x1021
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [31:0] d);
    logic [47:0] v;
    v = {c, 32'h0} ^ {d, 16'h0};
    for (int b = 47; b >= 16; b--)
      if (v[b]) v = v ^ (48'h11021 << (b - 16));
    return v[15:0];
  endfunction
  task automatic add_garbage(input logic [31:0] w);
    fifo_q.push_back(w);
    m_drops++;
  endtask
  task automatic add_frame(input logic [14:0] seq, input logic [63:0] ts, input bit bad_crc,
                           input logic [15:0] fcs_hi, input bit rnd);
    logic [15:0] c;
    logic [31:0] w;
    exp_t e;
    fifo_q.push_back({16'hCAFE, 1'b0, seq});
    fifo_q.push_back(ts[63:32]);
    fifo_q.push_back(ts[31:0]);
    c = 16'hFFFF;
    for (int i = 0; i < NS; i++) begin
      w = rnd ? $urandom : 32'(i);
      fifo_q.push_back(w);
      samp_q.push_back(w);
      c = ref_crc(c, w);
    end
    fifo_q.push_back({fcs_hi, c ^ {15'h0, bad_crc}});
    e.flags[3] = !m_first && ts != m_prev_ts + STEP;
    e.flags[2] = !m_first && int'(seq) != (int'(m_prev_seq) + 1) % 32768;
    e.flags[1] = fcs_hi != 16'hC0DE;
    e.flags[0] = bad_crc;
    if (e.flags == 4'd0) m_ok++;
    else m_bad++;
    m_prev_seq = seq;
    m_prev_ts = ts;
    m_first = e.flags[1];
    e.nok = 16'(m_ok);
    e.nbad = 16'(m_bad);
    e.drops = 16'(m_drops);
    e.seq = seq;
    e.ts = ts;
    frame_q.push_back(e);
  endtask
  task automatic wait_drain();
    int n;
    n = 0;
    while ((fifo_q.size() + samp_q.size() + frame_q.size()) != 0 && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    check("drain_pending", 64'(fifo_q.size() + samp_q.size() + frame_q.size()), 64'd0);
  endtask
  // FIFO model: first-word-fall-through head with random empty gaps
  initial begin
    bit pop;
    forever begin
      @(negedge i_clk);
      if (fifo_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        i_empty = 1'b0;
        i_data = fifo_q[0];
      end else begin
        i_empty = 1'b1;
        i_data = $urandom;
      end
      #1 pop = o_read;
      @(posedge i_clk);
      if (pop) void'(fifo_q.pop_front());
    end
  end
  // Monitor: pops expectations whenever the DUT strobes an output
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset_n) begin
      if (o_sample_valid) begin
        samples_seen++;
        if (samp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sample_unexpected: got %0h expected none", o_sample_data);
        end else check("sample", o_sample_data, samp_q.pop_front());
      end
      if (o_frame_done) begin
        if (frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected: got flags %0h expected none", o_err_flags);
        end else begin
          e = frame_q.pop_front();
          check("err_flags", o_err_flags, e.flags);
          check("frame_ok", o_frame_ok, e.flags == 4'd0);
          check("frames_ok", o_frames_ok, e.nok);
          check("frames_bad", o_frames_bad, e.nbad);
          check("hunt_drops", o_hunt_drops, e.drops);
          check("seqnum", o_seqnum, e.seq);
          check("timestamp", o_timestamp, e.ts);
        end
      end
    end
  end
  initial begin
    int base, n;
    logic [14:0] s;
    logic [63:0] t;
    repeat (3) @(negedge i_clk);
    #2;
    check("rst_read", o_read, 0);
    check("rst_valid", o_sample_valid, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_ok_cnt", o_frames_ok, 0);
    check("rst_bad_cnt", o_frames_bad, 0);
    check("rst_drops", o_hunt_drops, 0);
    check("rst_seq", o_seqnum, 0);
    check("rst_ts", o_timestamp, 0);
    check("rst_flags", o_err_flags, 0);
    @(negedge i_clk) i_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) add_garbage(32'h12345678);
    add_garbage(32'hCAFE8001);
    add_frame(15'd0, 64'd0, 0, 16'hC0DE, 0);
    add_frame(15'd1, 64'd64000, 0, 16'hC0DE, 0);
    wait_drain();
    check("drops_after_garbage", o_hunt_drops, 6);
    add_frame(15'd3, 64'd128000, 0, 16'hC0DE, 0);
    add_frame(15'd4, 64'd192000, 0, 16'hC0DE, 1);
    add_frame(15'd5, 64'd256000, 1, 16'hC0DE, 1);
    add_frame(15'd6, 64'd320000, 0, 16'hBEEF, 1);
    add_frame(15'd100, 64'd999, 0, 16'hC0DE, 1);
    add_frame(15'h7FFF, 64'hFFFF_FFFF_FFFF_0000, 0, 16'hC0DE, 1);
    add_frame(15'h0000, 64'hFFFF_FFFF_FFFF_0000 + STEP, 0, 16'hC0DE, 1);
    wait_drain();
    gap_pct = 30;
    base = samples_seen;
    add_frame(15'd1, m_prev_ts + STEP, 0, 16'hC0DE, 1);
    n = 0;
    while (samples_seen < base + 50 && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    check("reach_mid_payload", 64'(n < 5000), 1);
    i_sink_full = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      #2;
      check("hold_read", o_read, 0);
      check("hold_valid", o_sample_valid, 0);
    end
    i_sink_full = 1'b0;
    wait_drain();
    for (int k = 0; k < 4; k++) begin
      s = $urandom_range(1) ? m_prev_seq + 15'd1 : 15'($urandom);
      t = $urandom_range(1) ? m_prev_ts + STEP : {$urandom, $urandom};
      add_frame(s, t, $urandom_range(3) == 0, $urandom_range(4) == 0 ? 16'h1234 : 16'hC0DE, 1);
    end
    wait_drain();
    fifo_q.push_back({16'hCAFE, 1'b0, 15'd77});
    fifo_q.push_back(32'h0);
    fifo_q.push_back(32'h5);
    for (int i = 0; i < 100; i++) begin
      fifo_q.push_back(32'hA000_0000 + 32'(i));
      samp_q.push_back(32'hA000_0000 + 32'(i));
    end
    wait_drain();
    @(negedge i_clk) i_reset_n = 1'b0;
    @(negedge i_clk) i_reset_n = 1'b1;
    #2;
    check("mid_rst_ok_cnt", o_frames_ok, 0);
    check("mid_rst_bad_cnt", o_frames_bad, 0);
    check("mid_rst_drops", o_hunt_drops, 0);
    check("mid_rst_seq", o_seqnum, 0);
    check("mid_rst_ts", o_timestamp, 0);
    check("mid_rst_valid", o_sample_valid, 0);
    m_first = 1'b1;
    m_ok = 0;
    m_bad = 0;
    m_drops = 0;
    add_frame(15'd9, 64'd123, 0, 16'hC0DE, 1);
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
